// File: rtl/mips_core.sv
// mips_core: single-cycle 32-bit MIPS subset processor (add/sub/and/or, lw, sw).
// One instruction retires per rising clock edge. Instruction memory, register
// file and data memory live inside the core and are preloaded/inspected
// hierarchically (PC, instMem, mipsRegFile.registers, dataMem); none of them
// are cleared by reset.
//
// Ports:
//   clk - system clock, all state updates on the rising edge
//   rst - asynchronous active-high reset; forces PC to 0 and blocks all writes
//
// Parameters:
//   IMEM_DEPTH - instruction memory depth in 32-bit words (fetch wraps modulo)
//   DMEM_DEPTH - data memory depth in 32-bit words (addressing wraps modulo)
//
// Optional feature macro: MIPS_BRANCH_EN
//   defined   - beq (op 0x04) and j (op 0x02) redirect the PC
//   undefined - both opcodes execute as NOP

// Register file: two combinational read ports, one synchronous write port.
// Register 0 reads as zero and ignores writes. A read in the same cycle as a
// write to the same register returns the old value.
//
// Ports:
//   clk      - write clock
//   ra1/ra2  - read addresses; rd1/rd2 - read data
//   we/wa/wd - write enable, write address, write data
module mips_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

endmodule

module mips_core #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_BRANCH_EN
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
`endif

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  logic [31:0] PC;
  logic [31:0] instMem [0:IMEM_DEPTH-1];
  logic [31:0] dataMem [0:DMEM_DEPTH-1];

  logic [31:0]    ifull;
  logic [IAW-1:0] iidx;
  logic [31:0]    instr;
  logic [31:0]    pc_plus4;
  logic [31:0]    pc_next;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_ext;

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic [31:0]    ea;
  logic [31:0]    dfull;
  logic [DAW-1:0] didx;
  logic [31:0]    mem_rdata;

  logic        reg_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wd;
  logic        mem_we;

  // Fetch: word index of the PC, wrapped to the memory depth.
  assign ifull    = 32'(PC[31:2]) % IMEM_DEPTH;
  assign iidx     = ifull[IAW-1:0];
  assign instr    = instMem[iidx];
  assign pc_plus4 = PC + 32'd4;

  // Decode
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  mips_regfile mipsRegFile (
    .clk (clk),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (reg_we),
    .wa  (reg_wa),
    .wd  (reg_wd)
  );

  // Data addressing: byte offsets within a word are ignored, index wraps.
  assign ea        = rs_val + imm_ext;
  assign dfull     = 32'(ea[31:2]) % DMEM_DEPTH;
  assign didx      = dfull[DAW-1:0];
  assign mem_rdata = dataMem[didx];

  // Execute / write-back control
  always_comb begin
    reg_we = 1'b0;
    reg_wa = rd;
    reg_wd = 32'd0;
    mem_we = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_wa = rd;
        case (funct)
          FN_ADD: begin reg_we = 1'b1; reg_wd = rs_val + rt_val; end
          FN_SUB: begin reg_we = 1'b1; reg_wd = rs_val - rt_val; end
          FN_AND: begin reg_we = 1'b1; reg_wd = rs_val & rt_val; end
          FN_OR:  begin reg_we = 1'b1; reg_wd = rs_val | rt_val; end
          default: ;
        endcase
      end
      OP_LW: begin
        reg_we = 1'b1;
        reg_wa = rt;
        reg_wd = mem_rdata;
      end
      OP_SW: mem_we = 1'b1;
      default: ;
    endcase
    // The instruction pending during reset is abandoned.
    if (rst) begin
      reg_we = 1'b0;
      mem_we = 1'b0;
    end
  end

  // Next PC
  always_comb begin
    pc_next = pc_plus4;
`ifdef MIPS_BRANCH_EN
    if (op == OP_BEQ) begin
      if (rs_val == rt_val) begin
        pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
      end
    end else if (op == OP_J) begin
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC <= 32'd0;
    end else begin
      PC <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      dataMem[didx] <= rt_val;
    end
  end

  // Instruction memory has no write port of its own (it is loaded externally);
  // rewriting the fetched word keeps it a clocked storage array.
  always_ff @(posedge clk) begin
    instMem[iidx] <= instMem[iidx];
  end

  logic unused_bits;
  assign unused_bits = ^{instr[10:6], ifull[31:IAW], dfull[31:DAW], ea[1:0]};

endmodule

// File: tb/tb_mips_core.sv
// Self-checking bench for mips_core. A behavioural model executes the same
// program instruction by instruction and pushes the expected PC and the
// expected value of the written location into a queue; a monitor pops one
// entry after every retiring clock edge and compares against DUT state.
module tb_mips_core;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned DMEM_DEPTH = 256;
  localparam int unsigned RAND_STEPS = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_core #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_mem;
    int unsigned idx;
    logic [31:0] val;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  logic [31:0] m_imem [IMEM_DEPTH];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DMEM_DEPTH];
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Preload helpers keep the model and the DUT storage identical.
  task set_imem(input int unsigned i, input logic [31:0] w);
    m_imem[i] = w;
    dut.instMem[i] <= w;
  endtask

  task set_reg(input int unsigned i, input logic [31:0] w);
    m_regs[i] = w;
    dut.mipsRegFile.registers[i] <= w;
  endtask

  task set_dmem(input int unsigned i, input logic [31:0] w);
    m_dmem[i] = w;
    dut.dataMem[i] <= w;
  endtask

  // Architectural model: one instruction per call, straight from the ISA rules.
  task automatic model_step();
    logic [31:0] ins, a, b, res, ea, npc;
    logic [4:0]  r_s, r_t, r_d;
    int unsigned di;
    bit          wr;
    exp_t        e;
    ins = m_imem[(m_pc >> 2) % IMEM_DEPTH];
    r_s = ins[25:21];
    r_t = ins[20:16];
    r_d = ins[15:11];
    a   = m_regs[r_s];
    b   = m_regs[r_t];
    npc = m_pc + 32'd4;
    ea  = a + {{16{ins[15]}}, ins[15:0]};
    di  = (ea >> 2) % DMEM_DEPTH;
    e.is_mem = 1'b0;
    e.idx    = 0;
    e.val    = 32'd0;
    case (ins[31:26])
      6'h00: begin
        wr  = 1'b1;
        res = 32'd0;
        case (ins[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          default: wr = 1'b0;
        endcase
        if (wr && r_d != 5'd0) m_regs[r_d] = res;
        e.idx = r_d;
      end
      6'h23: begin
        if (r_t != 5'd0) m_regs[r_t] = m_dmem[di];
        e.idx = r_t;
      end
      6'h2B: begin
        m_dmem[di] = b;
        e.is_mem   = 1'b1;
        e.idx      = di;
      end
`ifdef MIPS_BRANCH_EN
      6'h04: if (a == b) npc = npc + ({{16{ins[15]}}, ins[15:0]} << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
`endif
      default: ;
    endcase
    e.val = e.is_mem ? m_dmem[e.idx] : m_regs[e.idx];
    m_pc  = npc;
    e.pc  = npc;
    exp_q.push_back(e);
  endtask

  task automatic model_run(input int unsigned n);
    m_pc = 32'd0;
    for (int k = 0; k < int'(n); k++) model_step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  r_s, r_t, r_d;
    logic [15:0] imm;
    r_s = 5'($urandom);
    r_t = 5'($urandom);
    r_d = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1:    return {6'h00, r_s, r_t, r_d, 5'd0, 6'h20};
      2:       return {6'h00, r_s, r_t, r_d, 5'd0, 6'h22};
      3:       return {6'h00, r_s, r_t, r_d, 5'd0, 6'h24};
      4:       return {6'h00, r_s, r_t, r_d, 5'd0, 6'h25};
      5:       return {6'h00, r_s, r_t, r_d, 5'd0, 6'($urandom)};
      6, 7:    return {6'h23, r_s, r_t, imm};
      8, 9:    return {6'h2B, r_s, r_t, imm};
      10:      return {6'h04, r_s, ($urandom_range(0, 1) == 0) ? r_s : r_t, 16'($urandom_range(0, 8))};
      default: return {6'($urandom), 26'($urandom)};
    endcase
  endfunction

  // Monitor: each retiring edge must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got no expected entry, required one per retired instruction");
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", dut.PC, e.pc);
          if (e.is_mem) check("sb_dmem", dut.dataMem[e.idx], e.val);
          else          check("sb_reg", dut.mipsRegFile.registers[e.idx], e.val);
        end
      end
    end
  end

  logic [31:0] prog [10];

  initial begin
    rst = 1'b1;
    #2;
    prog[0] = 32'h02309020;  // add $s2,$s1,$s0
    prog[1] = 32'h02309022;  // sub
    prog[2] = 32'h02309024;  // and
    prog[3] = 32'h02309025;  // or
    prog[4] = 32'hAE720004;  // sw $s2,4($s3)
    prog[5] = 32'h8E740004;  // lw $s4,4($s3)
    prog[6] = 32'hAE720104;  // sw $s2,0x104($s3)
    prog[7] = 32'h8E740004;  // lw $s4,4($s3)
    prog[8] = 32'h02300020;  // add $zero,$s1,$s0
    prog[9] = 32'hFC000000;  // unknown opcode 0x3F
    for (int i = 0; i < int'(IMEM_DEPTH); i++) set_imem(i, (i < 10) ? prog[i] : 32'd0);
    for (int r = 0; r < 32; r++) set_reg(r, (r == 0) ? 32'd0 : $urandom);
    for (int d = 0; d < int'(DMEM_DEPTH); d++) set_dmem(d, $urandom);
    set_reg(16, 32'h000004D2);
    set_reg(17, 32'h0000162E);
    set_reg(19, 32'h00000000);
    set_dmem(65, 32'h00000000);

    @(negedge clk);
    check("reset_pc", dut.PC, 32'd0);
    rst = 1'b0;
    model_run(10);
    mon_en = 1'b1;

    @(posedge clk); #2; check("add_r18", dut.mipsRegFile.registers[18], 32'h00001B00);
    @(posedge clk); #2; check("sub_r18", dut.mipsRegFile.registers[18], 32'h0000115C);
    @(posedge clk); #2; check("and_r18", dut.mipsRegFile.registers[18], 32'h00000402);
    @(posedge clk); #2; check("or_r18", dut.mipsRegFile.registers[18], 32'h000016FE);
    @(posedge clk); #2; check("sw_dmem1", dut.dataMem[1], 32'h000016FE);
    @(posedge clk); #2; check("lw_r20", dut.mipsRegFile.registers[20], 32'h000016FE);
    @(posedge clk); #2;
    check("sw_dmem65", dut.dataMem[65], 32'h000016FE);
    check("dmem1_kept", dut.dataMem[1], 32'h000016FE);
    @(posedge clk); #2; check("lw2_r20", dut.mipsRegFile.registers[20], 32'h000016FE);
    @(posedge clk); #2;
    check("r0_zero", dut.mipsRegFile.registers[0], 32'd0);
    check("r18_kept", dut.mipsRegFile.registers[18], 32'h000016FE);
    @(posedge clk); #2; check("nop_pc", dut.PC, 32'h00000028);
    @(negedge clk);
    mon_en = 1'b0;

    // Rerun to PC=0x14, then reset in the middle of the program.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_run(5);
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("mid_pc", dut.PC, 32'h00000014);
    set_reg(20, 32'hDEADBEEF);
    set_reg(18, 32'hCAFEF00D);
    set_dmem(1, 32'h12345678);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_pc", dut.PC, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_pc", dut.PC, 32'd0);
    check("rst_no_r20", dut.mipsRegFile.registers[20], 32'hDEADBEEF);
    check("rst_no_r18", dut.mipsRegFile.registers[18], 32'hCAFEF00D);
    check("rst_no_dmem1", dut.dataMem[1], 32'h12345678);
    @(negedge clk);
    rst = 1'b0;
    model_run(1);
    mon_en = 1'b1;
    @(posedge clk); #2;
    check("restart_r18", dut.mipsRegFile.registers[18], 32'h00001B00);
    check("restart_pc", dut.PC, 32'h00000004);
    @(negedge clk);
    mon_en = 1'b0;

    // Randomized program, long enough to wrap instruction memory.
    rst = 1'b1;
    for (int i = 0; i < int'(IMEM_DEPTH); i++) set_imem(i, rand_instr());
    for (int r = 1; r < 32; r++) set_reg(r, $urandom);
    for (int d = 0; d < int'(DMEM_DEPTH); d++) set_dmem(d, $urandom);
    @(negedge clk);
    rst = 1'b0;
    model_run(RAND_STEPS);
    mon_en = 1'b1;
    repeat (RAND_STEPS) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("final_r%0d", r), dut.mipsRegFile.registers[r], m_regs[r]);
    for (int d = 0; d < int'(DMEM_DEPTH); d++) check($sformatf("final_dmem%0d", d), dut.dataMem[d], m_dmem[d]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
